// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_PC = '0;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two synchronous FIFO with push/pop, synchronous
// flush and an occupancy count. Flush has priority over a same-cycle push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int AW      = clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          empty
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // The fetch unit reserves a slot per request, so a dropped push is a bug.
  assert property (@(posedge clk) disable iff (rst) !(push && !flush && full && !do_pop))
    else $error("fetch_fifo overflow");

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues sequential reads to a 1-cycle memory,
// buffers {pc, instr} pairs and hands them downstream; redirects flush all.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = DEFAULT_XLEN,
  parameter int              PC_STEP    = 1,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
  parameter int              FIFO_DEPTH = 4,
  localparam int             CW         = clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [CW-1:0]   fifo_count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic            empty;
  logic            issue;
  logic            pop;
  entry_t          head;
  entry_t          push_entry;

  // Handshake: a head entry transfers on any rising edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready.
  // An outstanding read holds a FIFO slot, so its return always has room.
  assign issue      = !rst && !redirect_valid &&
                      ((count + CW'(inflight)) < CW'(FIFO_DEPTH));
  assign imem_req   = issue;
  assign imem_addr  = fetch_pc;

  assign out_valid  = !empty && !redirect_valid;
  assign pop        = out_valid && out_ready;
  assign out_pc     = empty ? '0 : head.pc;
  assign out_instr  = empty ? '0 : head.instr;
  assign fifo_count = count;

  assign push_entry.pc    = inflight_pc;
  assign push_entry.instr = imem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + XLEN'(PC_STEP);
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (inflight),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  assert property (@(posedge clk) disable iff (rst) imem_req |-> !redirect_valid)
    else $error("fetch_unit issued during redirect");

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, wrap and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  fifo_count;

  logic        req4;
  logic [31:0] addr4;
  logic [31:0] rdata4 = '0;
  logic        r4_valid = 1'b0;
  logic [31:0] r4_pc = '0;
  logic        valid4;
  logic        ready4 = 1'b1;
  logic [31:0] pc4;
  logic [31:0] instr4;
  logic [2:0]  count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .fifo_count(fifo_count)
  );

  fetch_unit #(.PC_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .imem_req(req4), .imem_addr(addr4),
    .imem_rdata(rdata4), .redirect_valid(r4_valid), .redirect_pc(r4_pc),
    .out_valid(valid4), .out_ready(ready4), .out_pc(pc4),
    .out_instr(instr4), .fifo_count(count4)
  );

  // Memory models: word at address a holds a + 0x1000, one cycle after the request.
  always @(posedge clk) if (imem_req) imem_rdata <= imem_addr + 32'h1000;
  always @(posedge clk) if (req4) rdata4 <= addr4 + 32'h1000;

  task automatic adv();
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench sampling cycle 0, the first cycle after reset release.
  task automatic do_reset(input logic ready);
    rst = 1'b1;
    redirect_valid = 1'b0;
    r4_valid = 1'b0;
    out_ready = ready;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(c)) begin
        errors++; $display("FAIL stream_req c%0d: got req=%b addr=%h expected req=1 addr=%h", c, imem_req, imem_addr, 32'(c));
      end
      checks++;
      if (c < 2) begin
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid c%0d: got %b expected 0", c, out_valid); end
      end else if (out_valid !== 1'b1 || out_pc !== 32'(c - 2) || out_instr !== 32'h1000 + 32'(c - 2)) begin
        errors++; $display("FAIL stream_out c%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                           c, out_valid, out_pc, out_instr, 32'(c - 2), 32'h1000 + 32'(c - 2));
      end
      adv();
    end
  endtask

  task automatic test_stall();
    logic [2:0] exp_cnt;
    do_reset(1'b0);
    for (int c = 0; c < 20; c++) begin
      if (c == 10) out_ready = 1'b1;
      if (c < 10) begin
        exp_cnt = (c < 2) ? 3'd0 : (c > 5) ? 3'd4 : 3'(c - 1);
        checks++;
        if (fifo_count !== exp_cnt || imem_req !== (c < 4)) begin
          errors++; $display("FAIL stall_fill c%0d: got count=%0d req=%b expected count=%0d req=%b", c, fifo_count, imem_req, exp_cnt, (c < 4));
        end
        if (c >= 2) begin
          checks++;
          if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h1000) begin
            errors++; $display("FAIL stall_hold c%0d: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=1000", c, out_valid, out_pc, out_instr);
          end
        end
      end else begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'(c - 10) || out_instr !== 32'h1000 + 32'(c - 10)) begin
          errors++; $display("FAIL stall_drain c%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                             c, out_valid, out_pc, out_instr, 32'(c - 10), 32'h1000 + 32'(c - 10));
        end
        if (c >= 11) begin
          checks++;
          if (imem_req !== 1'b1 || imem_addr !== 32'(c - 7)) begin
            errors++; $display("FAIL stall_resume c%0d: got req=%b addr=%h expected req=1 addr=%h", c, imem_req, imem_addr, 32'(c - 7));
          end
        end
      end
      adv();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) adv();
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL redir_setup: got count=%0d expected 3", fifo_count); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL redir_r: got v=%b req=%b expected v=0 req=0", out_valid, imem_req);
    end
    adv();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (fifo_count !== 3'd0 || out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL redir_r1: got count=%0d v=%b req=%b addr=%h expected count=0 v=0 req=1 addr=40", fifo_count, out_valid, imem_req, imem_addr);
    end
    adv();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_r2: got v=%b expected 0", out_valid); end
    adv();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h1040) begin
      errors++; $display("FAIL redir_r3: got v=%b pc=%h instr=%h expected v=1 pc=40 instr=1040", out_valid, out_pc, out_instr);
    end
    adv();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h41 || out_instr !== 32'h1041) begin
      errors++; $display("FAIL redir_r4: got v=%b pc=%h instr=%h expected v=1 pc=41 instr=1041", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_back_to_back_redirect();
    do_reset(1'b1);
    for (int c = 0; c < 3; c++) adv();
    for (int k = 0; k < 3; k++) begin
      redirect_valid = 1'b1;
      redirect_pc = 32'h10 * 32'(k + 1);
      #1;
      checks++;
      if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL multi_redir k%0d: got req=%b v=%b expected req=0 v=0", k, imem_req, out_valid);
      end
      adv();
    end
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h30 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL multi_redir_first: got req=%b addr=%h count=%0d expected req=1 addr=30 count=0", imem_req, imem_addr, fifo_count);
    end
    adv();
    checks++;
    if (imem_addr !== 32'h31 || out_valid !== 1'b0) begin
      errors++; $display("FAIL multi_redir_second: got addr=%h v=%b expected addr=31 v=0", imem_addr, out_valid);
    end
    adv();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h30 || out_instr !== 32'h1030) begin
      errors++; $display("FAIL multi_redir_out: got v=%b pc=%h instr=%h expected v=1 pc=30 instr=1030", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    r4_valid = 1'b1;
    r4_pc = 32'hFFFF_FFFC;
    #1;
    checks++; if (req4 !== 1'b0) begin errors++; $display("FAIL wrap_redir: got req=%b expected 0", req4); end
    adv();
    r4_valid = 1'b0;
    #1;
    checks++;
    if (req4 !== 1'b1 || addr4 !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_top: got req=%b addr=%h expected req=1 addr=fffffffc", req4, addr4);
    end
    adv();
    checks++; if (addr4 !== 32'h0) begin errors++; $display("FAIL wrap_zero: got addr=%h expected 0", addr4); end
    adv();
    checks++;
    if (addr4 !== 32'h4 || valid4 !== 1'b1 || pc4 !== 32'hFFFF_FFFC || instr4 !== 32'h0000_0FFC) begin
      errors++; $display("FAIL wrap_out0: got addr=%h v=%b pc=%h instr=%h expected addr=4 v=1 pc=fffffffc instr=ffc", addr4, valid4, pc4, instr4);
    end
    adv();
    checks++;
    if (pc4 !== 32'h0 || instr4 !== 32'h1000) begin
      errors++; $display("FAIL wrap_out1: got pc=%h instr=%h expected pc=0 instr=1000", pc4, instr4);
    end
    adv();
    checks++;
    if (pc4 !== 32'h4 || instr4 !== 32'h1004) begin
      errors++; $display("FAIL wrap_out2: got pc=%h instr=%h expected pc=4 instr=1004", pc4, instr4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int c = 0; c < 3; c++) adv();
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rstmid_setup: got count=%0d expected 2", fifo_count); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0 || fifo_count !== 3'd0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++; $display("FAIL rstmid_async: got v=%b req=%b count=%0d pc=%h instr=%h expected all 0",
                         out_valid, imem_req, fifo_count, out_pc, out_instr);
    end
    adv();
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rstmid_restart: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
    out_ready = 1'b1;
    adv();
    adv();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h1000) begin
      errors++; $display("FAIL rstmid_out: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=1000", out_valid, out_pc, out_instr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back_redirect();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end.
- Drives a synchronous instruction memory with 1-cycle read latency.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to the decode/operand-fetch stage over a valid/ready handshake.
- Supports back-pressure (stall) and branch redirect with flush, replacing the free-running PC plus fixed IF/OF register.

Parameters:
- XLEN, 32, width of PC and instruction word.
- PC_STEP, 1, PC increment per sequential fetch (word-addressed memory).
- RESET_PC, 0, PC value loaded on reset.
- FIFO_DEPTH, 4, fetch-buffer entries; power of two, ≥2.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- imem_req, out, 1, read request this cycle.
- imem_addr, out, XLEN, read address; valid when imem_req=1.
- imem_rdata, in, XLEN, read data for the request issued in the previous cycle.
- redirect_valid, in, 1, branch taken / flush.
- redirect_pc, in, XLEN, new fetch PC.
- out_valid, out, 1, head entry available.
- out_ready, in, 1, consumer accepts head.
- out_pc, out, XLEN, PC of head entry.
- out_instr, out, XLEN, instruction of head entry.
- fifo_count, out, clog2(FIFO_DEPTH)+1, occupied entries.

Behaviour:
- State:
  - fetch_pc.
  - inflight bit, plus inflight_pc.
  - FIFO storage, rd_ptr, wr_ptr, count.
- Reset (async):
  - fetch_pc=RESET_PC; inflight=0; pointers and count=0.
  - Outputs: out_valid=0, imem_req=0, fifo_count=0, out_pc/out_instr=0.
- Issue rule (combinational from registered state):
  - imem_req = !redirect_valid && (count + inflight < FIFO_DEPTH).
  - imem_addr = fetch_pc.
- On issue edge:
  - fetch_pc += PC_STEP, modulo 2^XLEN; wrap from all-ones to 0 is silent.
  - inflight=1, inflight_pc=fetch_pc.
- Return:
  - When inflight=1, imem_rdata is pushed into the FIFO with inflight_pc at the next edge.
  - inflight clears unless a new request is issued the same cycle.
- Latency and throughput:
  - Request in cycle N → data on imem_rdata in N+1 → FIFO write at end of N+1 → out_valid in N+2.
  - Steady state: one instruction per cycle while out_ready=1.
- Credit accounting:
  - The in-flight slot is reserved, so a push never finds the FIFO full.
  - Overflow is impossible by construction; flag it with an assertion.
- Output:
  - out_valid = (count≠0) && !redirect_valid.
  - Pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Pop when empty does nothing.
- Redirect (redirect_valid=1 in cycle R):
  - No request in R; out_valid forced 0 in R.
  - At the edge ending R: FIFO cleared (count=0, pointers=0); inflight=0, so any data returning in R+1 is discarded; fetch_pc=redirect_pc.
  - First request in R+1 at redirect_pc; its instruction is visible in R+3.
- Redirect in consecutive cycles: the last one wins; nothing is issued while it is held.
- Redirect while inflight: the stale return is dropped even though imem_rdata is driven.
- Stall: with out_ready=0, the FIFO fills and issue stops at count+inflight=FIFO_DEPTH. No instruction is lost or duplicated; fetch resumes the cycle after the first pop.
- Reset mid-operation: everything returns to reset values immediately. The first request after release goes to RESET_PC.
- out_pc/out_instr hold the head entry and are stable while out_valid && !out_ready.

Decomposition:
- Package fetch_pkg:
  - XLEN default.
  - RESET_PC default.
  - fetch_entry_t struct {pc, instr}.
  - clog2 helper.
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t with push, pop, synchronous flush and count.
  - Keeps fetch_unit to PC/credit/redirect control.

Test Plan:
- Reset release, out_ready=1, memory word i = 0x1000+i:
  - imem_addr sequence 0,1,2,…
  - out_valid first in cycle 2.
  - out_instr 0x1000,0x1001,… back-to-back with matching out_pc.
- out_ready=0 for 10 cycles:
  - imem_req drops after count+inflight=4.
  - fifo_count=4.
  - On release, PCs continue 4,5,… with no gap or repeat.
- Redirect to 0x40 while inflight and FIFO holds 3 entries:
  - out_valid=0 in R.
  - Stale data discarded.
  - Next output is pc=0x40 with instr 0x1040 in R+3.
- Redirect asserted 3 consecutive cycles with targets 0x10, 0x20, 0x30:
  - Only 0x30 is fetched.
  - No request during the redirects.
- With PC_STEP=4 and fetch_pc=0xFFFFFFFC:
  - Next address is 0x00000000.
  - No output-order disruption.
- Assert rst mid-stream with FIFO half full:
  - Outputs are zero immediately (async).
  - After release, fetch restarts at RESET_PC.
